// File: rtl/signed_arith_pkg.sv
// Shared helpers for two's-complement arithmetic blocks.
// Saturation limits are returned at MaxWidth and sliced down by the user.
package signed_arith_pkg;

  localparam int unsigned MaxWidth = 64;

  // Largest positive value of a width-bit signed number (0 followed by ones).
  function automatic logic [MaxWidth-1:0] smax(input int unsigned width);
    return (MaxWidth'(1) << (width - 1)) - MaxWidth'(1);
  endfunction

  // Most negative value of a width-bit signed number (1 followed by zeros).
  function automatic logic [MaxWidth-1:0] smin(input int unsigned width);
    return MaxWidth'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/signed_addsub_core.sv
// Combinational signed add/subtract producing a WIDTH+1 bit exact result.
module signed_addsub_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH:0]   wide_o
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] b_op;

  // One extra bit makes A - MIN exact, so no separate negate overflow exists.
  always_comb begin
    a_ext  = {a_i[WIDTH-1], a_i};
    b_ext  = {b_i[WIDTH-1], b_i};
    b_op   = sub_i ? (~b_ext + (WIDTH+1)'(1)) : b_ext;
    wide_o = a_ext + b_op;
  end

endmodule

// File: rtl/signed_addsub_ovf_pipe.sv
// Two-stage valid/ready signed add/subtract with overflow detection, optional
// saturation and overflow statistics (saturating count plus sticky flag).
module signed_addsub_ovf_pipe
  import signed_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic             up_sub,
  input  logic             up_sat,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_res,
  output logic             down_overflow,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] ovf_count,
  output logic             ovf_sticky
);

  localparam logic [WIDTH-1:0] ResMax = WIDTH'(smax(WIDTH));
  localparam logic [WIDTH-1:0] ResMin = WIDTH'(smin(WIDTH));

  typedef struct packed {
    logic [WIDTH:0] sum;
    logic           sat;
  } s1_payload_t;

  logic           s1_valid_q;
  s1_payload_t    s1_q;
  logic           s2_valid_q;
  logic [WIDTH-1:0] s2_res_q;
  logic           s2_ovf_q;
  logic [CNT_W-1:0] cnt_q;
  logic           sticky_q;

  logic           s1_ready;
  logic           s2_ready;
  logic [WIDTH:0] core_wide;
  logic           s2_ovf_d;
  logic [WIDTH-1:0] s2_res_d;
  logic           ovf_event;

  signed_addsub_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i    (up_a),
    .b_i    (up_b),
    .sub_i  (up_sub),
    .wide_o (core_wide)
  );

  always_comb begin
    s2_ready = ~s2_valid_q | down_ready;
    s1_ready = ~s1_valid_q | s2_ready;
    up_ready = s1_ready;
  end

  // Top two bits disagree exactly when the sum does not fit in WIDTH bits.
  always_comb begin
    s2_ovf_d = s1_q.sum[WIDTH] ^ s1_q.sum[WIDTH-1];
    s2_res_d = s1_q.sum[WIDTH-1:0];
    if (s1_q.sat && s2_ovf_d) begin
      s2_res_d = s1_q.sum[WIDTH] ? ResMin : ResMax;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (s1_ready) begin
      s1_valid_q <= up_valid;
      if (up_valid) begin
        s1_q <= '{sum: core_wide, sat: up_sat};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_ovf_q   <= 1'b0;
    end else if (s2_ready) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_res_q <= s2_res_d;
        s2_ovf_q <= s2_ovf_d;
      end
    end
  end

  assign ovf_event = s2_valid_q & down_ready & s2_ovf_q;

  // A clear in the same cycle as an overflow delivery drops that event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else if (clr_stats) begin
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else if (ovf_event) begin
      sticky_q <= 1'b1;
      if (cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign down_valid    = s2_valid_q;
  assign down_res      = s2_res_q;
  assign down_overflow = s2_ovf_q;
  assign ovf_count     = cnt_q;
  assign ovf_sticky    = sticky_q;

endmodule

// File: tb/tb_signed_addsub_ovf_pipe.sv
// Bench for signed_addsub_ovf_pipe: integer reference model with an in-order
// expectation queue, plus directed vectors with literal expected results.
module tb_signed_addsub_ovf_pipe;

  localparam int W    = 8;
  localparam int CW   = 8;
  localparam int MAXI = (1 << (W - 1)) - 1;
  localparam int MINI = -(1 << (W - 1));
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_valid;
  logic          up_ready;
  logic [W-1:0]  up_a;
  logic [W-1:0]  up_b;
  logic          up_sub;
  logic          up_sat;
  logic          down_valid;
  logic          down_ready;
  logic [W-1:0]  down_res;
  logic          down_overflow;
  logic          clr_stats;
  logic [CW-1:0] ovf_count;
  logic          ovf_sticky;

  int checks = 0;
  int errors = 0;

  signed_addsub_ovf_pipe #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .up_valid      (up_valid),
    .up_ready      (up_ready),
    .up_a          (up_a),
    .up_b          (up_b),
    .up_sub        (up_sub),
    .up_sat        (up_sat),
    .down_valid    (down_valid),
    .down_ready    (down_ready),
    .down_res      (down_res),
    .down_overflow (down_overflow),
    .clr_stats     (clr_stats),
    .ovf_count     (ovf_count),
    .ovf_sticky    (ovf_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=0x%0h req=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: exact integer arithmetic, then range test and clamp/wrap.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sub, input logic sat,
                                output logic [W-1:0] r, output logic o);
    int ai;
    int bi;
    int t;
    ai = int'($signed(a));
    bi = int'($signed(b));
    t  = sub ? ai - bi : ai + bi;
    o  = (t > MAXI) || (t < MINI);
    if (o && sat) r = (t > 0) ? W'(MAXI) : W'(MINI);
    else          r = W'(t);
  endfunction

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t         q[$];
  exp_t         e;
  int           cyc = 0;
  int           mcnt = 0;
  bit           msticky = 0;
  bit           lat_en = 0;
  bit           prev_stall = 0;
  logic [W-1:0] prev_res;
  logic         prev_ovf;
  logic [W-1:0] mr;
  logic         mo;
  bit           ev;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      mcnt    = 0;
      msticky = 0;
    end else begin
      chk("ovf_count", 32'(ovf_count), 32'(mcnt));
      chk("ovf_sticky", 32'(ovf_sticky), 32'(msticky));
      if (prev_stall) begin
        chk("stall_valid", 32'(down_valid), 32'd1);
        chk("stall_res", 32'(down_res), 32'(prev_res));
        chk("stall_ovf", 32'(down_overflow), 32'(prev_ovf));
      end
      ev = 0;
      if (down_valid && down_ready) begin
        if (q.size() == 0) begin
          chk("spurious_result", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("res", 32'(down_res), 32'(e.res));
          chk("ovf", 32'(down_overflow), 32'(e.ovf));
          if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd2);
          ev = e.ovf;
        end
      end
      if (up_valid && up_ready) begin
        model(up_a, up_b, up_sub, up_sat, mr, mo);
        q.push_back('{res: mr, ovf: mo, acc: cyc, lat: lat_en});
      end
      if (clr_stats) begin
        mcnt    = 0;
        msticky = 0;
      end else if (ev) begin
        msticky = 1;
        if (mcnt < CMAX) mcnt++;
      end
    end
    prev_stall = !rst && down_valid && !down_ready;
    prev_res   = down_res;
    prev_ovf   = down_overflow;
  end

  bit toggle_en = 0;

  // All input changes happen 1 time unit after a rising edge, from this process only.
  task automatic step();
    @(posedge clk);
    #1;
    if (toggle_en) down_ready = ~down_ready;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic sat);
    bit got;
    got      = 0;
    up_valid = 1'b1;
    up_a     = a;
    up_b     = b;
    up_sub   = sub;
    up_sat   = sat;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = up_ready;
      step();
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic sat, input logic [W-1:0] xr, input logic xo);
    bit got;
    got = 0;
    drive(a, b, sub, sat);
    up_valid = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (down_valid) begin
        got = 1;
        chk("lit_res", 32'(down_res), 32'(xr));
        chk("lit_ovf", 32'(down_overflow), 32'(xo));
      end
      step();
    end
    if (!got) chk("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) step();
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    up_valid   = 1'b0;
    up_a       = '0;
    up_b       = '0;
    up_sub     = 1'b0;
    up_sat     = 1'b0;
    down_ready = 1'b1;
    clr_stats  = 1'b0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_down_valid", 32'(down_valid), 32'd0);
    chk("rst_down_res", 32'(down_res), 32'd0);
    chk("rst_down_ovf", 32'(down_overflow), 32'd0);
    chk("rst_count", 32'(ovf_count), 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    chk("rst_up_ready", 32'(up_ready), 32'd1);
    step();

    // Directed vectors with literal results.
    run_one(8'd100, 8'd50, 1'b0, 1'b0, 8'h96, 1'b1);
    run_one(8'd100, 8'd50, 1'b0, 1'b1, 8'h7F, 1'b1);
    run_one(8'd100, 8'd27, 1'b0, 1'b0, 8'h7F, 1'b0);
    run_one(8'h80, 8'd1, 1'b1, 1'b1, 8'h80, 1'b1);
    run_one(8'h80, 8'd1, 1'b1, 1'b0, 8'h7F, 1'b1);
    run_one(8'h00, 8'h80, 1'b1, 1'b0, 8'h80, 1'b1);
    run_one(8'h00, 8'h80, 1'b1, 1'b1, 8'h7F, 1'b1);
    run_one(8'hF6, 8'h05, 1'b1, 1'b1, 8'hF1, 1'b0);
    wait_drain();

    // Continuous stream with down_ready held high: fixed latency, no bubbles.
    lat_en = 1;
    for (int i = 0; i < 8; i++) drive(W'(i * 37), W'(i * 91), 1'(i), 1'(i >> 1));
    up_valid = 1'b0;
    lat_en   = 0;
    wait_drain();

    // Back-to-back random traffic under a 1,0,1,0 down_ready pattern.
    down_ready = 1'b1;
    toggle_en  = 1;
    for (int i = 0; i < 16; i++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end
    up_valid = 1'b0;
    wait_drain();
    toggle_en  = 0;
    down_ready = 1'b1;
    step();

    // Saturating overflow counter.
    for (int i = 0; i < 300; i++) drive(8'd100, 8'd50, 1'b0, 1'b0);
    up_valid = 1'b0;
    wait_drain();
    step();
    @(negedge clk);
    chk("count_saturated", 32'(ovf_count), 32'(CMAX));
    chk("sticky_set", 32'(ovf_sticky), 32'd1);
    step();

    // Asynchronous reset with two items in flight.
    down_ready = 1'b0;
    drive(8'd1, 8'd2, 1'b0, 1'b0);
    drive(8'd3, 8'd4, 1'b0, 1'b0);
    up_valid = 1'b0;
    chk("pre_rst_valid", 32'(down_valid), 32'd1);
    chk("pre_rst_up_ready", 32'(up_ready), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(down_valid), 32'd0);
    chk("async_rst_up_ready", 32'(up_ready), 32'd1);
    chk("async_rst_count", 32'(ovf_count), 32'd0);
    step();
    step();
    rst        = 1'b0;
    down_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_count", 32'(ovf_count), 32'd0);
    chk("post_rst_sticky", 32'(ovf_sticky), 32'd0);
    chk("post_rst_valid", 32'(down_valid), 32'd0);
    step();

    // Clear in the same cycle as an overflowing delivery.
    for (int i = 0; i < 3; i++) drive(8'h80, 8'h01, 1'b1, 1'b1);
    up_valid = 1'b0;
    wait_drain();
    chk("pre_clr_count", 32'(ovf_count), 32'd3);
    drive(8'd100, 8'd50, 1'b0, 1'b1);
    up_valid = 1'b0;
    step();
    clr_stats = 1'b1;
    @(negedge clk);
    chk("clr_event_present", 32'(down_valid && down_overflow), 32'd1);
    step();
    clr_stats = 1'b0;
    @(negedge clk);
    chk("clr_count", 32'(ovf_count), 32'd0);
    chk("clr_sticky", 32'(ovf_sticky), 32'd0);
    step();
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
